// File: rtl/ifft8_serial.sv
// ifft8_serial: streaming 8-point radix-2 DIT inverse FFT with one
// time-multiplexed butterfly. A frame is loaded in bit-reversed order,
// transformed in place over 12 cycles, then streamed out in natural order.
// Optional feature macro: IFFT8_ROUND_EN (round-half-up instead of floor).
module ifft8_serial #(
  parameter int DATA_W = 12,
  parameter int INT_W  = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic                     out_last,
  output logic                     busy
);

  // Wide enough for (B_re +/- B_im) * 181 without overflow.
  localparam int PW = INT_W + 10;
  localparam logic signed [PW-1:0]    C181    = PW'(181);
  localparam logic signed [INT_W-1:0] SAT_MAX = INT_W'((1 <<< (DATA_W - 1)) - 1);
  localparam logic signed [INT_W-1:0] SAT_MIN = INT_W'(-(1 <<< (DATA_W - 1)));

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_DRAIN} state_t;

  state_t state_reg, state_next;
  logic [2:0] in_cnt_reg, out_cnt_reg;
  logic [3:0] calc_cnt_reg;
  logic signed [INT_W-1:0] buf_re_reg [8];
  logic signed [INT_W-1:0] buf_im_reg [8];

  logic       in_fire, out_fire;
  logic [2:0] wr_addr, addr_a, addr_b, half;
  logic [1:0] tw_k;
  logic signed [PW-1:0] a_re_x, a_im_x, b_re_x, b_im_x;
  logic signed [PW-1:0] b_sum, b_dif, t_re, t_im, s_re, s_im, d_re, d_im;

  function automatic logic signed [PW-1:0] sx(input logic signed [INT_W-1:0] v);
    return {{(PW - INT_W){v[INT_W-1]}}, v};
  endfunction

  function automatic logic signed [PW-1:0] shr1(input logic signed [PW-1:0] v);
`ifdef IFFT8_ROUND_EN
    return (v + PW'(1)) >>> 1;
`else
    return v >>> 1;
`endif
  endfunction

  function automatic logic signed [PW-1:0] shr8(input logic signed [PW-1:0] v);
`ifdef IFFT8_ROUND_EN
    return (v + PW'(128)) >>> 8;
`else
    return v >>> 8;
`endif
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [INT_W-1:0] v);
    logic signed [INT_W-1:0] c;
    c = v;
    if (v > SAT_MAX) c = SAT_MAX;
    if (v < SAT_MIN) c = SAT_MIN;
    return c[DATA_W-1:0];
  endfunction

  assign in_ready  = (state_reg == S_LOAD);
  assign out_valid = (state_reg == S_DRAIN);
  assign busy      = (state_reg == S_CALC) || (state_reg == S_DRAIN);
  assign out_last  = out_valid && (out_cnt_reg == 3'd7);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wr_addr   = {in_cnt_reg[0], in_cnt_reg[1], in_cnt_reg[2]};
  assign out_re    = out_valid ? sat(buf_re_reg[out_cnt_reg]) : '0;
  assign out_im    = out_valid ? sat(buf_im_reg[out_cnt_reg]) : '0;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_LOAD;
    else      state_reg <= state_next;
  end

  // Next-state: load 8 bins, 12 butterfly cycles, drain 8 samples.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_LOAD:  if (in_fire && in_cnt_reg == 3'd7)   state_next = S_CALC;
      S_CALC:  if (calc_cnt_reg == 4'd11)           state_next = S_DRAIN;
      S_DRAIN: if (out_fire && out_cnt_reg == 3'd7) state_next = S_LOAD;
      default: state_next = S_LOAD;
    endcase
  end

  // Input, butterfly and output counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt_reg   <= '0;
      out_cnt_reg  <= '0;
      calc_cnt_reg <= '0;
    end else begin
      if (in_fire)  in_cnt_reg  <= in_cnt_reg + 3'd1;
      if (out_fire) out_cnt_reg <= out_cnt_reg + 3'd1;
      if (state_reg == S_CALC) calc_cnt_reg <= (calc_cnt_reg == 4'd11) ? 4'd0 : calc_cnt_reg + 4'd1;
    end
  end

  // Butterfly addressing: stage = calc_cnt[3:2], butterfly = calc_cnt[1:0].
  // Partner distance doubles per stage; the twiddle index is the position
  // within the group scaled to the 8-point circle.
  always_comb begin
    addr_a = '0;
    half   = 3'd1;
    tw_k   = '0;
    case (calc_cnt_reg[3:2])
      2'd0: begin
        addr_a = {calc_cnt_reg[1:0], 1'b0};
        half   = 3'd1;
        tw_k   = 2'd0;
      end
      2'd1: begin
        addr_a = {calc_cnt_reg[1], 1'b0, calc_cnt_reg[0]};
        half   = 3'd2;
        tw_k   = {calc_cnt_reg[0], 1'b0};
      end
      default: begin
        addr_a = {1'b0, calc_cnt_reg[1:0]};
        half   = 3'd4;
        tw_k   = calc_cnt_reg[1:0];
      end
    endcase
    addr_b = addr_a + half;
  end

  // Twiddle multiply by conjugated W8^k, then halving add/subtract.
  always_comb begin
    a_re_x = sx(buf_re_reg[addr_a]);
    a_im_x = sx(buf_im_reg[addr_a]);
    b_re_x = sx(buf_re_reg[addr_b]);
    b_im_x = sx(buf_im_reg[addr_b]);
    b_sum  = b_re_x + b_im_x;
    b_dif  = b_re_x - b_im_x;
    t_re   = b_re_x;
    t_im   = b_im_x;
    case (tw_k)
      2'd1: begin
        t_re = shr8(b_dif * C181);
        t_im = shr8(b_sum * C181);
      end
      2'd2: begin
        t_re = -b_im_x;
        t_im = b_re_x;
      end
      2'd3: begin
        t_re = shr8((-b_sum) * C181);
        t_im = shr8(b_dif * C181);
      end
      default: ;
    endcase
    s_re = shr1(a_re_x + t_re);
    s_im = shr1(a_im_x + t_im);
    d_re = shr1(a_re_x - t_re);
    d_im = shr1(a_im_x - t_im);
  end

  // One complex buffer word per address: bit-reversed load or butterfly write-back.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_buf
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          buf_re_reg[gi] <= '0;
          buf_im_reg[gi] <= '0;
        end else if (in_fire && wr_addr == 3'(gi)) begin
          buf_re_reg[gi] <= {{(INT_W - DATA_W){in_re[DATA_W-1]}}, in_re};
          buf_im_reg[gi] <= {{(INT_W - DATA_W){in_im[DATA_W-1]}}, in_im};
        end else if (state_reg == S_CALC && addr_a == 3'(gi)) begin
          buf_re_reg[gi] <= s_re[INT_W-1:0];
          buf_im_reg[gi] <= s_im[INT_W-1:0];
        end else if (state_reg == S_CALC && addr_b == 3'(gi)) begin
          buf_re_reg[gi] <= d_re[INT_W-1:0];
          buf_im_reg[gi] <= d_im[INT_W-1:0];
        end
      end
    end
  endgenerate

endmodule
